// File: rtl/controle_jogo_drone.sv
// Main control FSM of the drone game: menu selection, movement requests,
// hard-mode obstacle scheduling, collision handling and win/lose sequencing.
module controle_jogo_drone #(
    parameter int TEMPO_REPETE       = 1000,
    parameter int PERIODO_OBSTACULO  = 2000,
    parameter int TEMPO_INVULNERAVEL = 200,
    parameter int VIDAS_MAX          = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic [1:0] controle_vertical,
    input  logic [1:0] controle_horizontal,
    input  logic       colisao,
    input  logic       chegou_fim,
    output logic       zera,
    output logic       conta_h,
    output logic       sentido_h,
    output logic       conta_v,
    output logic       sentido_v,
    output logic       atualiza_obstaculos,
    output logic       registra_colisao,
    output logic [1:0] modo,
    output logic [1:0] vidas,
    output logic       venceu,
    output logic       perdeu,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ESCOLHE_MODO  = 4'h2,
        ESCOLHE_VIDAS = 4'h3,
        ESPERA_JOGADA = 4'h4,
        MOVE          = 4'h5,
        VERIFICA      = 4'h6,
        COLISAO       = 4'h7,
        INVULNERAVEL  = 4'h8,
        VENCEU        = 4'h9,
        PERDEU        = 4'hA
    } estado_t;

    localparam int REP_W = $clog2(TEMPO_REPETE + 1);
    localparam int OBS_W = $clog2(PERIODO_OBSTACULO + 1);
    localparam int INV_W = $clog2(TEMPO_INVULNERAVEL + 1);
    localparam logic [REP_W-1:0] REP_FIM     = REP_W'(TEMPO_REPETE - 1);
    localparam logic [OBS_W-1:0] OBS_FIM     = OBS_W'(PERIODO_OBSTACULO - 1);
    localparam logic [OBS_W-1:0] OBS_RECARGA = OBS_W'(1);
    localparam logic [INV_W-1:0] INV_FIM     = INV_W'(TEMPO_INVULNERAVEL - 1);
    localparam logic [1:0]       VIDAS_LIM   = 2'(VIDAS_MAX);

    estado_t          estado_q, estado_d;
    logic [1:0]       modo_q, modo_d, vidas_q, vidas_d;
    logic             confirma_q;
    logic [1:0]       vert_q, horiz_q;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [OBS_W-1:0] obs_cnt_q, obs_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic             atualiza_q, atualiza_d;
    logic             mov_vert_q, mov_vert_d, mov_sent_q, mov_sent_d;

    function automatic logic [1:0] normaliza(input logic [1:0] c);
        return (c == 2'b01 || c == 2'b10) ? c : 2'b00;
    endfunction

    logic [1:0] vert_n, horiz_n, vert_p, horiz_p;
    logic       confirma_borda, borda_v, borda_h, cmd_mudou, cmd_ativo;
    logic       repete_ativo, rep_dispara, req_v, req_h, pedido;
    logic       obs_ativo, obs_expira;

    assign vert_n         = normaliza(controle_vertical);
    assign horiz_n        = normaliza(controle_horizontal);
    assign vert_p         = normaliza(vert_q);
    assign horiz_p        = normaliza(horiz_q);
    assign confirma_borda = confirma && !confirma_q;
    assign borda_v        = (vert_n != 2'b00) && (vert_p == 2'b00);
    assign borda_h        = (horiz_n != 2'b00) && (horiz_p == 2'b00);
    assign cmd_mudou      = {vert_n, horiz_n} != {vert_p, horiz_p};
    assign cmd_ativo      = (vert_n != 2'b00) || (horiz_n != 2'b00);

    // The repeat counter keeps running through MOVE/VERIFICA so held moves stay evenly spaced.
    assign repete_ativo = (estado_q == ESPERA_JOGADA) || (estado_q == MOVE) || (estado_q == VERIFICA);
    assign rep_dispara  = repete_ativo && cmd_ativo && !cmd_mudou && (rep_cnt_q == REP_FIM);
    assign req_v        = borda_v || (rep_dispara && vert_n != 2'b00);
    assign req_h        = borda_h || (rep_dispara && vert_n == 2'b00 && horiz_n != 2'b00);
    assign pedido       = req_v || req_h;

    assign obs_ativo  = (estado_q == ESPERA_JOGADA) && (modo_q == 2'b01);
    assign obs_expira = obs_ativo && !atualiza_q && (obs_cnt_q >= OBS_FIM);

    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (!repete_ativo || !cmd_ativo || cmd_mudou || rep_cnt_q == REP_FIM)
            rep_cnt_d = '0;
        inv_cnt_d = (estado_q == INVULNERAVEL) ? inv_cnt_q + 1'b1 : '0;
    end

    // Reload at 1 credits the VERIFICA cycle after each update, keeping idle updates one period apart.
    always_comb begin
        obs_cnt_d  = obs_cnt_q;
        atualiza_d = 1'b0;
        if (estado_q == PREPARA || modo_q != 2'b01) begin
            obs_cnt_d = '0;
        end else if (obs_ativo) begin
            if (obs_expira) begin
                if (!pedido) begin
                    obs_cnt_d  = OBS_RECARGA;
                    atualiza_d = 1'b1;
                end
            end else begin
                obs_cnt_d = obs_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        estado_d   = estado_q;
        modo_d     = modo_q;
        vidas_d    = vidas_q;
        mov_vert_d = mov_vert_q;
        mov_sent_d = mov_sent_q;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARA;
            PREPARA: begin
                modo_d   = 2'b00;
                vidas_d  = 2'b01;
                estado_d = ESCOLHE_MODO;
            end
            ESCOLHE_MODO: begin
                if (borda_v) modo_d = (vert_n == 2'b01) ? 2'b01 : 2'b00;
                if (confirma_borda) estado_d = ESCOLHE_VIDAS;
            end
            ESCOLHE_VIDAS: begin
                if (borda_v && vert_n == 2'b01 && vidas_q < VIDAS_LIM) vidas_d = vidas_q + 2'd1;
                if (borda_v && vert_n == 2'b10 && vidas_q > 2'd1)      vidas_d = vidas_q - 2'd1;
                if (confirma_borda) estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // The update pulse cycle only hands over to VERIFICA; requests in it are dropped.
                if (atualiza_q) begin
                    estado_d = VERIFICA;
                end else if (req_v) begin
                    estado_d   = MOVE;
                    mov_vert_d = 1'b1;
                    mov_sent_d = (vert_n == 2'b01);
                end else if (req_h) begin
                    estado_d   = MOVE;
                    mov_vert_d = 1'b0;
                    mov_sent_d = (horiz_n == 2'b01);
                end
            end
            MOVE: estado_d = VERIFICA;
            VERIFICA: begin
                if (colisao)         estado_d = COLISAO;
                else if (chegou_fim) estado_d = VENCEU;
                else                 estado_d = ESPERA_JOGADA;
            end
            COLISAO: begin
                if (vidas_q <= 2'd1) begin
                    vidas_d  = 2'b00;
                    estado_d = PERDEU;
                end else begin
                    vidas_d  = vidas_q - 2'd1;
                    estado_d = INVULNERAVEL;
                end
            end
            INVULNERAVEL: if (inv_cnt_q == INV_FIM) estado_d = ESPERA_JOGADA;
            VENCEU, PERDEU: if (iniciar) estado_d = PREPARA;
            default: estado_d = INICIAL;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            modo_q     <= 2'b00;
            vidas_q    <= 2'b00;
            confirma_q <= 1'b0;
            vert_q     <= 2'b00;
            horiz_q    <= 2'b00;
            rep_cnt_q  <= '0;
            obs_cnt_q  <= '0;
            inv_cnt_q  <= '0;
            atualiza_q <= 1'b0;
            mov_vert_q <= 1'b0;
            mov_sent_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            modo_q     <= modo_d;
            vidas_q    <= vidas_d;
            confirma_q <= confirma;
            vert_q     <= controle_vertical;
            horiz_q    <= controle_horizontal;
            rep_cnt_q  <= rep_cnt_d;
            obs_cnt_q  <= obs_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            atualiza_q <= atualiza_d;
            mov_vert_q <= mov_vert_d;
            mov_sent_q <= mov_sent_d;
        end
    end

    assign zera                = (estado_q == PREPARA);
    assign conta_v             = (estado_q == MOVE) && mov_vert_q;
    assign sentido_v           = conta_v && mov_sent_q;
    assign conta_h             = (estado_q == MOVE) && !mov_vert_q;
    assign sentido_h           = conta_h && mov_sent_q;
    assign atualiza_obstaculos = atualiza_q;
    assign registra_colisao    = (estado_q == COLISAO);
    assign modo                = modo_q;
    assign vidas               = vidas_q;
    assign venceu              = (estado_q == VENCEU);
    assign perdeu              = (estado_q == PERDEU);
    assign db_estado           = estado_q;

endmodule

// File: tb/tb_controle_jogo_drone.sv
// Directed bench for the drone game controller: menus, held moves, priority,
// collisions with invulnerability, hard-mode obstacle period, win and lose.
`timescale 1ns/1ps
module tb_controle_jogo_drone;
    logic       clock = 1'b0;
    logic       reset, iniciar, confirma, colisao, chegou_fim;
    logic [1:0] cv, ch;
    logic       zera, conta_h, sentido_h, conta_v, sentido_v;
    logic       atualiza_obstaculos, registra_colisao, venceu, perdeu;
    logic [1:0] modo, vidas;
    logic [3:0] db_estado;

    controle_jogo_drone dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .confirma            (confirma),
        .controle_vertical   (cv),
        .controle_horizontal (ch),
        .colisao             (colisao),
        .chegou_fim          (chegou_fim),
        .zera                (zera),
        .conta_h             (conta_h),
        .sentido_h           (sentido_h),
        .conta_v             (conta_v),
        .sentido_v           (sentido_v),
        .atualiza_obstaculos (atualiza_obstaculos),
        .registra_colisao    (registra_colisao),
        .modo                (modo),
        .vidas               (vidas),
        .venceu              (venceu),
        .perdeu              (perdeu),
        .db_estado           (db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int excl_err = 0;
    int n_zera = 0;
    int n_reg = 0;
    int h_times[$];
    int v_times[$];
    int a_times[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (conta_h === 1'b1) h_times.push_back(cyc);
            if (conta_v === 1'b1) v_times.push_back(cyc);
            if (atualiza_obstaculos === 1'b1) a_times.push_back(cyc);
            if (zera === 1'b1) n_zera++;
            if (registra_colisao === 1'b1) n_reg++;
            if (int'(zera) + int'(conta_h) + int'(conta_v) + int'(atualiza_obstaculos)
                + int'(registra_colisao) > 1) excl_err++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gap(input int q[$], input int i);
        return (q.size() > i + 1) ? q[i+1] - q[i] : -1;
    endfunction

    int n0, nv0, nr0, na0, s0;

    initial begin
        reset = 1'b1; iniciar = 1'b0; confirma = 1'b0;
        cv = 2'b00; ch = 2'b00; colisao = 1'b0; chegou_fim = 1'b0;
        tick(2);
        check("rst_estado", db_estado, 0);
        check("rst_modo", modo, 0);
        check("rst_vidas", vidas, 0);
        check("rst_saidas", {zera, conta_h, conta_v, atualiza_obstaculos, registra_colisao, venceu, perdeu}, 0);
        reset = 1'b0;
        tick(1);
        check("inicial_parado", db_estado, 0);

        // Game 1: easy mode, three lives
        iniciar = 1'b1;
        tick(1);
        check("prepara", db_estado, 1);
        check("prepara_zera", zera, 1);
        tick(1);
        check("escolhe_modo", db_estado, 2);
        check("modo_inicial", modo, 0);
        check("vidas_inicial", vidas, 1);
        tick(3);
        iniciar = 1'b0;
        check("iniciar_mantido", db_estado, 2);
        check("zera_unico", n_zera, 1);
        confirma = 1'b1;
        tick(1);
        check("escolhe_vidas", db_estado, 3);
        cv = 2'b01; tick(1);
        check("vidas_2", vidas, 2);
        cv = 2'b00; tick(1); cv = 2'b01; tick(1);
        check("vidas_3", vidas, 3);
        cv = 2'b00; tick(1); cv = 2'b01; tick(1);
        check("vidas_sat_max", vidas, 3);
        cv = 2'b00; tick(1); cv = 2'b10; tick(1);
        check("vidas_desce", vidas, 2);
        cv = 2'b00; tick(1); cv = 2'b01; tick(1);
        check("vidas_sobe", vidas, 3);
        check("confirma_mantido", db_estado, 3);
        cv = 2'b00; confirma = 1'b0; tick(1);
        confirma = 1'b1; tick(1);
        confirma = 1'b0;
        check("espera_jogada", db_estado, 4);
        check("modo_facil", modo, 0);

        // Held forward move: one pulse in 500 cycles, three in 2500
        n0 = h_times.size();
        ch = 2'b01; tick(1);
        check("move_h_pulso", conta_h, 1);
        check("move_h_sentido", sentido_h, 1);
        check("move_h_sem_v", conta_v, 0);
        tick(499); ch = 2'b00; tick(5);
        check("h_500_pulsos", h_times.size() - n0, 1);
        n0 = h_times.size();
        ch = 2'b01; tick(2500); ch = 2'b00; tick(5);
        check("h_2500_pulsos", h_times.size() - n0, 3);
        check("h_espaco_1", gap(h_times, n0), 1000);
        check("h_espaco_2", gap(h_times, n0 + 1), 1000);

        // Vertical wins over horizontal in the same cycle
        check("espera_antes_prio", db_estado, 4);
        n0 = h_times.size(); nv0 = v_times.size();
        cv = 2'b01; ch = 2'b01; tick(1);
        check("prio_conta_v", conta_v, 1);
        check("prio_sentido_v", sentido_v, 1);
        check("prio_sem_h", conta_h, 0);
        cv = 2'b00; ch = 2'b00; tick(3);
        check("prio_h_total", h_times.size() - n0, 0);
        check("prio_v_total", v_times.size() - nv0, 1);
        cv = 2'b10; tick(1);
        check("desce_conta_v", conta_v, 1);
        check("desce_sentido_v", sentido_v, 0);
        cv = 2'b00; tick(3);

        // Reset in the middle of a game
        check("pre_rst_vidas", vidas, 3);
        reset = 1'b1; tick(1);
        check("rst_jogo_estado", db_estado, 0);
        check("rst_jogo_modo", modo, 0);
        check("rst_jogo_vidas", vidas, 0);
        reset = 1'b0;

        // Game 2: easy mode, two lives, lose
        iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
        confirma = 1'b1; tick(1); confirma = 1'b0;
        check("j2_escolhe_vidas", db_estado, 3);
        cv = 2'b10; tick(1);
        check("vidas_sat_min", vidas, 1);
        cv = 2'b00; tick(1); cv = 2'b01; tick(1);
        check("j2_vidas_2", vidas, 2);
        cv = 2'b00; confirma = 1'b1; tick(1); confirma = 1'b0;
        check("j2_espera", db_estado, 4);
        n0 = h_times.size(); nr0 = n_reg;
        ch = 2'b01; tick(1);
        colisao = 1'b1; tick(2);
        check("colisao_estado", db_estado, 7);
        check("colisao_registra", registra_colisao, 1);
        tick(1); colisao = 1'b0;
        check("invuln_estado", db_estado, 8);
        check("invuln_vidas", vidas, 1);
        tick(199);
        check("invuln_ainda", db_estado, 8);
        tick(1);
        check("invuln_sai", db_estado, 4);
        tick(500); ch = 2'b00; tick(2);
        check("invuln_sem_move", h_times.size() - n0, 1);
        check("registra_1", n_reg - nr0, 1);
        ch = 2'b01; tick(1);
        colisao = 1'b1; tick(2);
        check("colisao2_registra", registra_colisao, 1);
        colisao = 1'b0; ch = 2'b00; tick(1);
        check("perdeu_estado", db_estado, 10);
        check("perdeu_vidas", vidas, 0);
        check("perdeu_flag", perdeu, 1);
        check("perdeu_sem_venceu", venceu, 0);
        check("registra_2", n_reg - nr0, 2);

        // Game 3: hard mode, two lives, obstacle period, collision precedence, win
        iniciar = 1'b1; tick(1);
        check("j3_prepara", db_estado, 1);
        iniciar = 1'b0; tick(1);
        check("j3_modo_limpo", modo, 0);
        cv = 2'b01; tick(1);
        check("modo_dificil", modo, 1);
        cv = 2'b00; confirma = 1'b1; tick(1); confirma = 1'b0;
        cv = 2'b01; tick(1);
        check("j3_vidas_2", vidas, 2);
        cv = 2'b00; confirma = 1'b1; tick(1); confirma = 1'b0;
        check("j3_espera", db_estado, 4);
        na0 = a_times.size(); s0 = cyc;
        tick(4100);
        check("obst_pulsos", a_times.size() - na0, 2);
        check("obst_primeiro", (a_times.size() > na0) ? a_times[na0] - s0 : -1, 2000);
        check("obst_espaco", gap(a_times, na0), 2000);
        ch = 2'b01; tick(1);
        colisao = 1'b1; chegou_fim = 1'b1; tick(2);
        check("prec_colisao", db_estado, 7);
        check("prec_sem_venceu", venceu, 0);
        colisao = 1'b0; chegou_fim = 1'b0; ch = 2'b00; tick(1);
        check("j3_vidas_1", vidas, 1);
        tick(200);
        check("j3_volta_espera", db_estado, 4);
        ch = 2'b01; tick(1);
        chegou_fim = 1'b1; tick(2);
        check("venceu_estado", db_estado, 9);
        check("venceu_flag", venceu, 1);
        check("venceu_sem_perdeu", perdeu, 0);
        chegou_fim = 1'b0; ch = 2'b00; tick(3);
        check("venceu_mantido", venceu, 1);
        iniciar = 1'b1; tick(1);
        check("reinicia_prepara", db_estado, 1);
        iniciar = 1'b0; tick(2);
        check("pulsos_exclusivos", excl_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controle_jogo_drone.md
Name: controle_jogo_drone

Overview:
- Main control FSM for the drone simulator. Sequences the game: mode selection, lives selection, movement, obstacle updates, collision handling, win and lose.
- Drives the datapath's position counters, obstacle register and collision counter with single-cycle enable pulses.
- Reads back the datapath status flags `colisao` and `chegou_fim`.
- Sits between the top-level player inputs and the datapath inside the simulator top.

Parameters:
- TEMPO_REPETE, 1000: cycles a held direction command must persist before it issues another move pulse.
- PERIODO_OBSTACULO, 2000: cycles between obstacle-update pulses in hard mode.
- TEMPO_INVULNERAVEL, 200: cycles the FSM spends in INVULNERAVEL after a non-fatal collision.
- VIDAS_MAX, 3: saturation limit for lives selection (range 1..3, fits in 2 bits).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start or restart game (level).
- confirma  in  1  confirm selection; rising edge used.
- controle_vertical  in  2  01=up, 10=down, 00/11=none.
- controle_horizontal  in  2  01=forward, 10=back, 00/11=none.
- colisao  in  1  datapath: drone cell overlaps an obstacle; valid the cycle after a move or obstacle pulse.
- chegou_fim  in  1  datapath: horizontal position equals the last column.
- zera  out  1  clear datapath positions, obstacles and collision counter.
- conta_h  out  1  one-cycle horizontal move pulse.
- sentido_h  out  1  1=forward, 0=back; qualifies conta_h.
- conta_v  out  1  one-cycle vertical move pulse.
- sentido_v  out  1  1=up, 0=down; qualifies conta_v.
- atualiza_obstaculos  out  1  one-cycle obstacle-shift pulse (hard mode only).
- registra_colisao  out  1  one-cycle collision-counter increment.
- modo  out  2  00=easy, 01=hard.
- vidas  out  2  remaining lives.
- venceu  out  1  high in VENCEU.
- perdeu  out  1  high in PERDEU.
- db_estado  out  4  state encoding.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to INICIAL.
  - All pulse outputs, venceu and perdeu are 0.
  - modo=00, vidas=00, all timers 0.
  - Edge-detect registers are cleared to 0, so an input already held high when reset releases counts as an edge.
  - Reset overrides everything mid-game.
- Edge detection: inputs are registered once. A rising edge of confirma, or a transition of either command from none to a valid code, is detected the cycle after the input changes.
- Output style: pulse outputs are Moore-style or registered, exactly 1 cycle wide, and mutually exclusive.
- INICIAL (0):
  - Wait for iniciar=1, then go to PREPARA.
- PREPARA (1):
  - zera=1 for one cycle; modo=00, vidas=01.
  - Go to ESCOLHE_MODO.
- ESCOLHE_MODO (2):
  - Up-edge sets modo=01; down-edge sets modo=00.
  - confirma edge goes to ESCOLHE_VIDAS.
- ESCOLHE_VIDAS (3):
  - Up-edge increments vidas, saturating at VIDAS_MAX; down-edge decrements vidas, saturating at 1.
  - confirma edge goes to ESPERA_JOGADA.
  - A confirma held high from ESCOLHE_MODO does not count; a fresh edge is required.
- ESPERA_JOGADA (4): a move request comes from a command edge, or from a command held for TEMPO_REPETE cycles.
  - Repeat counter: resets whenever the active command changes; when it reaches TEMPO_REPETE-1 it issues a request and restarts.
  - Vertical has priority over horizontal if both are active in the same cycle; the horizontal request is dropped, not queued.
  - A move request goes to MOVE.
- MOVE (5):
  - Exactly one of conta_v/sentido_v or conta_h/sentido_h is pulsed.
  - Go to VERIFICA.
- Obstacle timer (hard mode):
  - Runs only while modo=01 and the state is ESPERA_JOGADA.
  - On expiry it pulses atualiza_obstaculos for 1 cycle, then goes to VERIFICA.
  - If the timer expires in the same cycle as a move request, the move wins and the obstacle update is deferred to the next ESPERA_JOGADA cycle.
  - In easy mode the timer is held at 0.
- VERIFICA (6):
  - Samples colisao and chegou_fim.
  - colisao=1 goes to COLISAO; this takes precedence over chegou_fim.
  - Otherwise chegou_fim=1 goes to VENCEU.
  - Otherwise go to ESPERA_JOGADA.
- COLISAO (7):
  - registra_colisao=1 for one cycle.
  - If vidas==1: vidas becomes 0, go to PERDEU.
  - Otherwise: vidas decrements by 1, go to INVULNERAVEL.
- INVULNERAVEL (8):
  - All commands and the obstacle timer are ignored for TEMPO_INVULNERAVEL cycles, then go to ESPERA_JOGADA.
  - The repeat counter is cleared on exit, so a command still held does not move until TEMPO_REPETE elapses or a new edge occurs.
- VENCEU (9) / PERDEU (A):
  - venceu or perdeu is held at 1.
  - iniciar=1 goes to PREPARA.
- Encodings B–F: unused; any of them goes to INICIAL on the next cycle.

Test Plan:
1. Reset at any point, e.g. in INICIAL, then during ESPERA_JOGADA with vidas=3 -> next cycle: db_estado=0, modo=00, vidas=00, all pulses 0.
2. iniciar 5 cycles, confirma with vertical=00, two up-edges, confirma edge -> zera pulses once, modo=00, vidas=11, db_estado=4.
3. Horizontal 01 held 500 cycles -> exactly one conta_h pulse with sentido_h=1. Held 2500 cycles -> exactly 3 pulses, spaced 1000 cycles.
4. Vertical 01 and horizontal 01 asserted in the same cycle -> only conta_v pulses (sentido_v=1), no conta_h.
5. With vidas=2, force colisao=1 after a move -> registra_colisao pulses once, vidas=01, 200 ignored cycles. Second collision -> vidas=00, perdeu=1, db_estado=A.
6. Hard mode, no input -> atualiza_obstaculos every 2000 cycles. colisao=1 together with chegou_fim=1 in VERIFICA -> COLISAO, venceu stays 0. chegou_fim alone -> venceu=1, then iniciar -> PREPARA.
